// File: rtl/gsr_pulse_sequencer.sv
// GSR pulse initiator: accept one request, drive plrest for a clamped length, settle, pulse done.
// Optional pulse counter is built when GSR_PULSE_COUNTER_EN is defined.
module gsr_pulse_sequencer #(
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned MIN_PULSE = 4,
    parameter int unsigned SETTLE    = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [LEN_W-1:0] req_len,
    input  logic [LEN_W-1:0] req_settle,
    output logic             plrest,
    output logic             busy,
    output logic             done,
    output logic [31:0]      pulse_cnt
);

    typedef enum logic [1:0] {StIdle, StAssert, StSettle, StDone} state_e;

    state_e           state_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] set_q;
    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] set_eff;
    logic             accept;
    logic             pulse_end;

    always_comb begin
        len_eff   = (req_len < LEN_W'(MIN_PULSE)) ? LEN_W'(MIN_PULSE) : req_len;
        set_eff   = (req_settle == '0) ? LEN_W'(SETTLE) : req_settle;
        // req_ready is only ever high in StIdle, so this cannot fire mid-sequence
        accept    = req_valid && req_ready;
        pulse_end = (state_q == StAssert) && (cnt_q == '0);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            set_q     <= '0;
            plrest    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            req_ready <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        state_q   <= StAssert;
                        cnt_q     <= len_eff - LEN_W'(1);
                        set_q     <= set_eff;
                        plrest    <= 1'b1;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                    end
                end
                StAssert: begin
                    if (cnt_q == '0) begin
                        state_q <= StSettle;
                        plrest  <= 1'b0;
                        cnt_q   <= set_q - LEN_W'(1);
                    end else begin
                        cnt_q <= cnt_q - LEN_W'(1);
                    end
                end
                StSettle: begin
                    if (cnt_q == '0) begin
                        state_q <= StDone;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - LEN_W'(1);
                    end
                end
                StDone: begin
                    state_q   <= StIdle;
                    req_ready <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef GSR_PULSE_COUNTER_EN
    logic [31:0] pulse_cnt_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pulse_cnt_q <= 32'd0;
        end else if (pulse_end && (pulse_cnt_q != 32'hFFFF_FFFF)) begin
            pulse_cnt_q <= pulse_cnt_q + 32'd1;
        end
    end

    assign pulse_cnt = pulse_cnt_q;
`else
    logic unused_pulse_end;
    assign unused_pulse_end = pulse_end;
    assign pulse_cnt        = 32'd0;
`endif

endmodule

// File: tb/tb_gsr_pulse_sequencer.sv
// Self-checking bench for gsr_pulse_sequencer: timeline model per accepted request.
// Honours GSR_PULSE_COUNTER_EN for the expected pulse_cnt value.
module tb_gsr_pulse_sequencer;

    localparam int unsigned MinPulse = 4;
    localparam int unsigned SettleDef = 32;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_len;
    logic [15:0] req_settle;
    logic        plrest;
    logic        busy;
    logic        done;
    logic [31:0] pulse_cnt;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned exp_pulses = 0;

    always #5 clk = ~clk;

    gsr_pulse_sequencer dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_len    (req_len),
        .req_settle (req_settle),
        .plrest     (plrest),
        .busy       (busy),
        .done       (done),
        .pulse_cnt  (pulse_cnt)
    );

    function automatic logic [31:0] exp_count(input int unsigned n);
`ifdef GSR_PULSE_COUNTER_EN
        return 32'(n);
`else
        return 32'(n) & 32'd0;
`endif
    endfunction

    // Drive one request from a negedge and check every cycle up to the next ready.
    // Observed vector: {plrest, busy, done, req_ready, pulse_cnt}.
    task automatic play_sequence(input int len, input int settle, input bit hold,
                                 input string tag, output int waited);
        int l;
        int s;
        logic [35:0] obs;
        logic [35:0] expv;
        l = (len < int'(MinPulse)) ? int'(MinPulse) : len;
        s = (settle == 0) ? int'(SettleDef) : settle;
        req_len    = 16'(len);
        req_settle = 16'(settle);
        req_valid  = 1'b1;
        waited     = 0;
        while (req_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (req_ready !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL %s accept_timeout: req_ready=%b required 1", tag, req_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
        // Inputs after accept must be ignored
        req_len    = 16'($urandom_range(0, 40));
        req_settle = 16'($urandom_range(0, 40));
        for (int o = 1; o <= l + s + 2; o++) begin
            @(negedge clk);
            obs  = {plrest, busy, done, req_ready, pulse_cnt};
            expv = {(o >= 1 && o <= l), (o >= 1 && o <= l + s), (o == l + s + 1),
                    (o == l + s + 2), exp_count(exp_pulses + ((o > l) ? 1 : 0))};
            n_vec++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL %s len=%0d set=%0d off=%0d: got plrest/busy/done/ready=%b cnt=%0d, required %b cnt=%0d",
                         tag, l, s, o, obs[35:32], obs[31:0], expv[35:32], expv[31:0]);
            end
        end
        exp_pulses++;
    endtask

    task automatic test_reset;
        logic [35:0] obs;
        resetn     = 1'b0;
        req_valid  = 1'b0;
        req_len    = '0;
        req_settle = '0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            obs = {plrest, busy, done, req_ready, pulse_cnt};
            n_vec++;
            if (obs[35:32] !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_hold: plrest/busy/done/ready=%b required 0000", obs[35:32]);
            end
        end
        resetn     = 1'b1;
        exp_pulses = 0;
        repeat (3) begin
            @(negedge clk);
            obs = {plrest, busy, done, req_ready, pulse_cnt};
            n_vec++;
            if (obs !== {4'b0001, 32'd0}) begin
                n_err++;
                $display("FAIL reset_release: plrest/busy/done/ready=%b cnt=%0d required 0001 cnt=0",
                         obs[35:32], obs[31:0]);
            end
        end
    endtask

    task automatic test_directed;
        int w;
        play_sequence(10, 5, 1'b0, "len10_set5", w);
        play_sequence(1, 0, 1'b0, "len1_clamp", w);
        play_sequence(4, 1, 1'b0, "len4_set1", w);
    endtask

    task automatic test_back_to_back;
        int w;
        for (int i = 0; i < 4; i++) begin
            play_sequence(int'($urandom_range(0, 9)), int'($urandom_range(0, 6)), (i != 3),
                          "back_to_back", w);
            if (i > 0) begin
                n_vec++;
                if (w !== 0) begin
                    n_err++;
                    $display("FAIL back_to_back_accept: waited %0d cycles, required 0", w);
                end
            end
        end
    endtask

    task automatic test_random;
        int w;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            play_sequence(int'($urandom_range(0, 12)), int'($urandom_range(0, 8)), 1'b0,
                          "random", w);
        end
    endtask

    task automatic test_reset_mid;
        logic [35:0] obs;
        @(negedge clk);
        req_len    = 16'd20;
        req_settle = 16'd3;
        req_valid  = 1'b1;
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_ready: req_ready=%b required 1", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int o = 1; o <= 3; o++) begin
            @(negedge clk);
            n_vec++;
            if ({plrest, busy, done} !== 3'b110) begin
                n_err++;
                $display("FAIL reset_mid_assert off=%0d: plrest/busy/done=%b required 110",
                         o, {plrest, busy, done});
            end
        end
        resetn = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({plrest, busy, done, req_ready} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_mid_drop: plrest/busy/done/ready=%b required 0000",
                     {plrest, busy, done, req_ready});
        end
        resetn     = 1'b1;
        exp_pulses = 0;
        @(negedge clk);
        for (int o = 0; o < 40; o++) begin
            obs = {plrest, busy, done, req_ready, pulse_cnt};
            n_vec++;
            if (obs !== {4'b0001, 32'd0}) begin
                n_err++;
                $display("FAIL reset_mid_after off=%0d: plrest/busy/done/ready=%b cnt=%0d required 0001 cnt=0",
                         o, obs[35:32], obs[31:0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_pulse_count;
        int w;
        resetn = 1'b0;
        @(negedge clk);
        resetn     = 1'b1;
        exp_pulses = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            play_sequence(int'($urandom_range(0, 6)), int'($urandom_range(1, 4)), 1'b0,
                          "count", w);
        end
        n_vec++;
`ifdef GSR_PULSE_COUNTER_EN
        if (pulse_cnt !== 32'd3) begin
            n_err++;
            $display("FAIL pulse_count: pulse_cnt=%0d required 3", pulse_cnt);
        end
`else
        if (pulse_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL pulse_count: pulse_cnt=%0d required 0", pulse_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_pulse_count();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
